// File: rtl/bsg_async_pkg.sv
// Shared definitions for the bundled-data clock-crossing blocks.
//   sync_stages_min_gp     : shallowest legal synchroniser chain
//   bsg_bundled_rx_state_e : receive holding-register state, kept as an enum
//                            so waveforms show EMPTY/FULL by name
package bsg_async_pkg;

    localparam int sync_stages_min_gp = 2;

    typedef enum logic {
        eEmpty = 1'b0,
        eFull  = 1'b1
    } bsg_bundled_rx_state_e;

endpackage

// File: rtl/bsg_sync_sync_chain.sv
// N-deep flop synchroniser with synchronous reset.
//   clk_i   : destination clock
//   reset_i : synchronous, active-high; loads reset_val_p into every stage
//   d_i     : asynchronous input bus (each bit must be independently safe to sync)
//   q_o     : synchronised output, stages_p edges behind d_i
// Stage 0 is the only flop that samples the asynchronous input. No logic sits
// between stages, so the whole chain settles metastability.
module bsg_sync_sync_chain #(
    parameter int                 width_p     = 1,
    parameter int                 stages_p    = 2,
    parameter logic [width_p-1:0] reset_val_p = '0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    logic [stages_p-1:0][width_p-1:0] s_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int k = 0; k < stages_p; k++) s_r[k] <= reset_val_p;
        end else begin
            s_r[0] <= d_i;
            for (int k = 1; k < stages_p; k++) s_r[k] <= s_r[k-1];
        end
    end

    assign q_o = s_r[stages_p-1];

endmodule

// File: rtl/bsg_sync_sync_bundled_rx.sv
// Receive side of a two-phase (toggle) bundled-data crossing into oclk.
//   oclk_i            : receive clock, the only clock here
//   oclk_reset_i      : synchronous, active-high reset
//   iclk_req_toggle_i : sender request toggle, one flip per word (asynchronous)
//   iclk_data_i       : bundled data, stable while a request is outstanding
//   oclk_v_o          : holding register contains an unconsumed word
//   oclk_data_o       : held word
//   oclk_yumi_i       : consumer takes the word this cycle
//   oclk_ack_toggle_o : flips once per consumed word (registered)
// A request is pending while the synchronised toggle differs from our ack.
// The data bus is only sampled while pending, when the sender holds it
// stable, so iclk_data_i -> data_r is a multicycle/false path.
module bsg_sync_sync_bundled_rx
    import bsg_async_pkg::*;
#(
    parameter int width_p       = 64,
    parameter int sync_stages_p = 2
) (
    input  logic               oclk_i,
    input  logic               oclk_reset_i,
    input  logic               iclk_req_toggle_i,
    input  logic [width_p-1:0] iclk_data_i,
    output logic               oclk_v_o,
    output logic [width_p-1:0] oclk_data_o,
    input  logic               oclk_yumi_i,
    output logic               oclk_ack_toggle_o
);

    if (sync_stages_p < sync_stages_min_gp) begin : g_bad_stages
        $error("sync_stages_p must be at least %0d", sync_stages_min_gp);
    end

    logic                  req_sync;
    logic                  pending;
    logic                  full_r;
    logic                  ack_r, ack_n;
    logic [width_p-1:0]    data_r, data_n;
    bsg_bundled_rx_state_e state_r, state_n;

    bsg_sync_sync_chain #(
        .width_p    (1),
        .stages_p   (sync_stages_p),
        .reset_val_p(1'b0)
    ) req_chain (
        .clk_i  (oclk_i),
        .reset_i(oclk_reset_i),
        .d_i    (iclk_req_toggle_i),
        .q_o    (req_sync)
    );

    assign pending = (req_sync != ack_r);
    assign full_r  = (state_r == eFull);

    always_ff @(posedge oclk_i) begin
        if (oclk_reset_i) begin
            state_r <= eEmpty;
            ack_r   <= 1'b0;
            data_r  <= '0;
        end else begin
            state_r <= state_n;
            ack_r   <= ack_n;
            data_r  <= data_n;
        end
    end

    // A request arriving while FULL is not lost: once the word is consumed
    // the ack flip leaves pending set and the new word is captured next edge.
    always_comb begin
        state_n = state_r;
        ack_n   = ack_r;
        data_n  = data_r;
        case (state_r)
            eEmpty: begin
                if (pending) begin
                    state_n = eFull;
                    data_n  = iclk_data_i;
                end
            end
            eFull: begin
                if (oclk_yumi_i) begin
                    state_n = eEmpty;
                    ack_n   = ~ack_r;
                end
            end
        endcase
    end

    assign oclk_v_o          = full_r;
    assign oclk_data_o       = data_r;
    assign oclk_ack_toggle_o = ack_r;

    // Protocol monitors. While FULL the captured request must stay
    // outstanding; losing pending means the sender flipped again early.
    yumi_when_empty: assert property (@(posedge oclk_i) disable iff (oclk_reset_i)
        !(oclk_yumi_i && !full_r))
        else $warning("bundled_rx protocol: yumi while empty, ignored");

    req_while_full: assert property (@(posedge oclk_i) disable iff (oclk_reset_i)
        !(full_r && !pending))
        else $warning("bundled_rx protocol: request flip while full, deferred");

endmodule
